// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath words, register indices, MEM-stage FSM states
// and the branch-resolution payloads.
package cpu_types_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned STALL_W = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  // MEM-stage access controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } memstate_t;

  // Control-flow flags carried in the EX/MEM latch
  typedef struct packed {
    logic jump;
    logic jr;
    logic branch;
    logic bne;
    logic zero;
  } brctl_t;

  // Candidate PC targets carried in the EX/MEM latch
  typedef struct packed {
    word_t rdat1;
    word_t jumpaddr;
    word_t branchaddr;
  } brtgt_t;

  // Saturating increment for the stall counter (sticks at all-ones)
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (v == '1) ? v : v + STALL_W'(1);
  endfunction

endpackage

// File: rtl/branch_resolver.sv
// Decides whether the instruction in MEM changes control flow and where to.
module branch_resolver
  import cpu_types_pkg::*;
(
  input  brctl_t ctl,
  input  brtgt_t tgt,
  output logic   taken,
  output word_t  pc_target
);

  // Taken condition and target select; jr outranks jump, branches fall through
  always_comb begin
    taken     = ctl.jump | ctl.jr | (ctl.branch & ctl.zero) | (ctl.bne & ~ctl.zero);
    pc_target = tgt.branchaddr;
    if (ctl.jr) begin
      pc_target = tgt.rdat1;
    end else if (ctl.jump) begin
      pc_target = tgt.jumpaddr;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-cache requests, stalls the pipe on a miss,
// resolves redirects once memory is quiet, and parks the core on halt.
module mem_stage_ctrl
  import cpu_types_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  // EX/MEM latch outputs
  input  logic               memread_o,
  input  logic               memwrite_o,
  input  logic               jump_o,
  input  logic               branch_o,
  input  logic               bne_o,
  input  logic               jr_o,
  input  logic               zero_o,
  input  logic               halt_o,
  input  word_t              aluoutput_o,
  input  word_t              rdat2_o,
  input  word_t              rdat1_o,
  input  word_t              jumpaddr_o,
  input  word_t              branchaddr_o,
  // data cache
  input  logic               dhit,
  input  word_t              dmemload,
  output logic               dmemREN,
  output logic               dmemWEN,
  output word_t              dmemaddr,
  output word_t              dmemstore,
  // pipeline control
  output logic               pcpause,
  output logic               nopmode,
  output logic               redirect,
  output word_t              pc_target,
  // results
  output word_t              loaddata,
  output logic               halt,
  output logic [STALL_W-1:0] stallcnt
);

  memstate_t state;
  memstate_t state_next;
  word_t     load_q;
  logic      req;
  logic      miss;
  logic      taken;
  logic      capture;
  brctl_t    br_ctl;
  brtgt_t    br_tgt;

  assign br_ctl = '{jump: jump_o, jr: jr_o, branch: branch_o, bne: bne_o, zero: zero_o};
  assign br_tgt = '{rdat1: rdat1_o, jumpaddr: jumpaddr_o, branchaddr: branchaddr_o};

  branch_resolver u_branch_resolver (
    .ctl       (br_ctl),
    .tgt       (br_tgt),
    .taken     (taken),
    .pc_target (pc_target)
  );

  // Next state plus cache, stall and redirect controls
  always_comb begin
    state_next = state;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    dmemaddr   = aluoutput_o;
    dmemstore  = rdat2_o;
    pcpause    = 1'b0;
    redirect   = 1'b0;
    nopmode    = 1'b0;
    halt       = 1'b0;
    capture    = 1'b0;
    req        = memread_o | memwrite_o;
    miss       = req & ~dhit;
    case (state)
      HALTED: begin
        // parked until reset: freeze everything, issue nothing
        pcpause    = 1'b1;
        halt       = 1'b1;
        state_next = HALTED;
      end
      default: begin
        dmemREN  = memread_o;
        dmemWEN  = memwrite_o;
        pcpause  = miss;
        redirect = taken & ~miss;
        nopmode  = taken & ~miss;
        capture  = memread_o & dhit;
        // an outstanding access outranks halt; halt only once memory is quiet
        if (miss) begin
          state_next = WAIT;
        end else if (halt_o) begin
          state_next = HALTED;
        end else begin
          state_next = IDLE;
        end
      end
    endcase
    loaddata = capture ? dmemload : load_q;
  end

  // State, captured load data and saturating stall counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      load_q   <= '0;
      stallcnt <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        load_q <= dmemload;
      end
      if (pcpause && (state != HALTED)) begin
        stallcnt <= sat_inc(stallcnt);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl.
module tb_mem_stage_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        memread_o, memwrite_o, jump_o, branch_o, bne_o, jr_o, zero_o, halt_o;
  word_t       aluoutput_o, rdat2_o, rdat1_o, jumpaddr_o, branchaddr_o;
  logic        dhit;
  word_t       dmemload;
  logic        dmemREN, dmemWEN;
  word_t       dmemaddr, dmemstore;
  logic        pcpause, nopmode, redirect;
  word_t       pc_target, loaddata;
  logic        halt;
  logic [15:0] stallcnt;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_ctrl dut (
    .CLK(CLK), .RST(RST),
    .memread_o(memread_o), .memwrite_o(memwrite_o), .jump_o(jump_o),
    .branch_o(branch_o), .bne_o(bne_o), .jr_o(jr_o), .zero_o(zero_o),
    .halt_o(halt_o), .aluoutput_o(aluoutput_o), .rdat2_o(rdat2_o),
    .rdat1_o(rdat1_o), .jumpaddr_o(jumpaddr_o), .branchaddr_o(branchaddr_o),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .pcpause(pcpause),
    .nopmode(nopmode), .redirect(redirect), .pc_target(pc_target),
    .loaddata(loaddata), .halt(halt), .stallcnt(stallcnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    memread_o = 0; memwrite_o = 0; jump_o = 0; branch_o = 0; bne_o = 0;
    jr_o = 0; zero_o = 0; halt_o = 0; dhit = 0;
    aluoutput_o = '0; rdat2_o = '0; rdat1_o = '0; jumpaddr_o = '0;
    branchaddr_o = '0; dmemload = '0;
  endtask

  task automatic do_reset();
    RST = 1;
    tick();
    RST = 0;
  endtask

  int wen_cnt;
  int pause_cnt;

  initial begin
    clear_inputs();
    do_reset();
    #1;
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_stallcnt", 32'(stallcnt), 32'h0);
    check("rst_loaddata", loaddata, 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_pcpause", 32'(pcpause), 32'h0);

    // load hit in the first cycle
    memread_o = 1; aluoutput_o = 32'h0000_0040; dhit = 1; dmemload = 32'hDEAD_BEEF;
    #1;
    check("ld_pcpause", 32'(pcpause), 32'h0);
    check("ld_ren", 32'(dmemREN), 32'h1);
    check("ld_addr", dmemaddr, 32'h0000_0040);
    check("ld_data_comb", loaddata, 32'hDEAD_BEEF);
    tick();
    clear_inputs();
    #1;
    check("ld_data_held", loaddata, 32'hDEAD_BEEF);
    check("ld_stallcnt", 32'(stallcnt), 32'h0);
    check("ld_state", 32'(dut.state), 32'(IDLE));

    // store miss, hit on the fourth cycle
    memwrite_o = 1; rdat2_o = 32'h1234_5678; aluoutput_o = 32'h0000_0080;
    wen_cnt = 0; pause_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      dhit = (c == 3);
      #1;
      wen_cnt += int'(dmemWEN);
      pause_cnt += int'(pcpause);
      if (c == 0) check("st_store", dmemstore, 32'h1234_5678);
      if (c == 2) check("st_state_wait", 32'(dut.state), 32'(WAIT));
      tick();
    end
    clear_inputs();
    #1;
    check("st_wen_cycles", 32'(wen_cnt), 32'd4);
    check("st_pause_cycles", 32'(pause_cnt), 32'd3);
    check("st_stallcnt", 32'(stallcnt), 32'd3);
    check("st_state_idle", 32'(dut.state), 32'(IDLE));
    check("st_loaddata_kept", loaddata, 32'hDEAD_BEEF);

    // branches
    bne_o = 1; zero_o = 0; branchaddr_o = 32'h0000_0100;
    #1;
    check("bne_redirect", 32'(redirect), 32'h1);
    check("bne_nopmode", 32'(nopmode), 32'h1);
    check("bne_target", pc_target, 32'h0000_0100);
    clear_inputs();
    branch_o = 1; zero_o = 0; branchaddr_o = 32'h0000_0100;
    #1;
    check("beq_nt_redirect", 32'(redirect), 32'h0);
    zero_o = 1;
    #1;
    check("beq_t_redirect", 32'(redirect), 32'h1);
    clear_inputs();
    jr_o = 1; rdat1_o = 32'h0000_0200; jump_o = 1; jumpaddr_o = 32'h0000_0300;
    #1;
    check("jr_target", pc_target, 32'h0000_0200);
    check("jr_redirect", 32'(redirect), 32'h1);
    jr_o = 0;
    #1;
    check("j_target", pc_target, 32'h0000_0300);
    // jump held off behind a load miss, released on dhit
    memread_o = 1; dhit = 0; dmemload = 32'hCAFE_F00D;
    #1;
    check("hold_redirect", 32'(redirect), 32'h0);
    check("hold_nopmode", 32'(nopmode), 32'h0);
    tick();
    dhit = 1;
    #1;
    check("rel_redirect", 32'(redirect), 32'h1);
    check("rel_loaddata", loaddata, 32'hCAFE_F00D);
    tick();
    clear_inputs();
    #1;
    check("rel_stallcnt", 32'(stallcnt), 32'd4);
    check("rel_loaddata_held", loaddata, 32'hCAFE_F00D);

    // halt with no request
    halt_o = 1;
    #1;
    check("hlt_pre_halt", 32'(halt), 32'h0);
    check("hlt_pre_pause", 32'(pcpause), 32'h0);
    tick();
    clear_inputs();
    memread_o = 1; jump_o = 1;
    #1;
    check("hlt_halt", 32'(halt), 32'h1);
    check("hlt_pause", 32'(pcpause), 32'h1);
    check("hlt_ren", 32'(dmemREN), 32'h0);
    check("hlt_redirect", 32'(redirect), 32'h0);
    check("hlt_state", 32'(dut.state), 32'(HALTED));
    tick();
    tick();
    check("hlt_sticky", 32'(halt), 32'h1);
    check("hlt_stallcnt_frozen", 32'(stallcnt), 32'd4);
    clear_inputs();
    do_reset();
    #1;
    check("hlt_rst_halt", 32'(halt), 32'h0);
    check("hlt_rst_state", 32'(dut.state), 32'(IDLE));
    check("hlt_rst_stallcnt", 32'(stallcnt), 32'h0);

    // request and halt together: halt waits for dhit
    memread_o = 1; halt_o = 1; dhit = 0;
    tick();
    #1;
    check("rqh_no_halt", 32'(halt), 32'h0);
    check("rqh_state_wait", 32'(dut.state), 32'(WAIT));
    dhit = 1;
    tick();
    #1;
    check("rqh_halt", 32'(halt), 32'h1);
    clear_inputs();
    do_reset();

    // reset in the middle of a miss
    memread_o = 1; dhit = 1; dmemload = 32'h5555_AAAA;
    tick();
    dhit = 0;
    tick();
    tick();
    #1;
    check("rmm_state_wait", 32'(dut.state), 32'(WAIT));
    check("rmm_stallcnt_pre", 32'(stallcnt), 32'd2);
    do_reset();
    #1;
    check("rmm_state", 32'(dut.state), 32'(IDLE));
    check("rmm_stallcnt", 32'(stallcnt), 32'h0);
    check("rmm_loaddata", loaddata, 32'h0);
    check("rmm_reissue", 32'(dmemREN), 32'h1);
    tick();
    #1;
    check("rmm_rewait", 32'(dut.state), 32'(WAIT));
    clear_inputs();
    do_reset();

    // stall counter saturation
    memread_o = 1; dhit = 0;
    repeat (65534) tick();
    check("sat_below", 32'(stallcnt), 32'h0000_FFFE);
    tick();
    check("sat_reach", 32'(stallcnt), 32'h0000_FFFF);
    repeat (4465) tick();
    check("sat_hold", 32'(stallcnt), 32'h0000_FFFF);
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
